// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed, active-low seven-segment scan:
// each anode/cathode pattern is synchronized, debounced, decoded and assembled into frames.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] digits_out,
  output logic        frame_valid,
  output logic        frame_pulse,
  output logic        code_err
);

  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);

  // Returns {legal, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] glyph_decode(input logic [6:0] gfedcba);
    logic [4:0] r;
    case (gfedcba)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Returns {one_hot_low, index}; blanked or ghosted anodes are not a digit.
  function automatic logic [2:0] anode_select(input logic [3:0] an);
    logic [2:0] r;
    case (an)
      4'b1110: r = 3'b1_00;
      4'b1101: r = 3'b1_01;
      4'b1011: r = 3'b1_10;
      4'b0111: r = 3'b1_11;
      default: r = 3'b0_00;
    endcase
    return r;
  endfunction

  logic [3:0]  an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [6:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [10:0] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] digits_q, digits_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_pulse_q, frame_pulse_d;
  logic        code_err_q, code_err_d;

  logic [10:0] samp;
  logic        accept, capture, bad_glyph, commit;
  logic [4:0]  glyph;
  logic [2:0]  sel;

  always_comb begin
    an_s1_d  = an_in;
    seg_s1_d = seg_in;
    an_s2_d  = an_s1_q;
    seg_s2_d = seg_s1_q;
    samp     = {an_s2_q, seg_s2_q};
    prev_d   = samp;

    if (samp != prev_q)        cnt_d = 8'd0;
    else if (cnt_q < CNT_SAT)  cnt_d = cnt_q + 8'd1;
    else                       cnt_d = cnt_q;

    // Counter passes through CNT_ACC once per dwell because it saturates above it.
    accept    = (cnt_d == CNT_ACC);
    glyph     = glyph_decode(~seg_s2_q);
    sel       = anode_select(an_s2_q);
    capture   = accept && sel[2] && glyph[4];
    bad_glyph = accept && sel[2] && !glyph[4];
    commit    = (mask_q == 4'hF);

    shadow_d = shadow_q;
    mask_d   = commit ? 4'h0 : mask_q;
    if (capture) begin
      shadow_d[{sel[1:0], 2'b00} +: 4] = glyph[3:0];
      mask_d[sel[1:0]]                 = 1'b1;
    end

    digits_d      = commit ? shadow_q : digits_q;
    frame_pulse_d = commit;
    frame_valid_d = frame_valid_q || commit;
    code_err_d    = bad_glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_s1_q       <= 4'hF;
      an_s2_q       <= 4'hF;
      seg_s1_q      <= 7'h7F;
      seg_s2_q      <= 7'h7F;
      prev_q        <= {4'hF, 7'h7F};
      cnt_q         <= 8'd0;
      mask_q        <= 4'h0;
      shadow_q      <= 16'h0000;
      digits_q      <= 16'h0000;
      frame_valid_q <= 1'b0;
      frame_pulse_q <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      an_s1_q       <= an_s1_d;
      an_s2_q       <= an_s2_d;
      seg_s1_q      <= seg_s1_d;
      seg_s2_q      <= seg_s2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      frame_pulse_q <= frame_pulse_d;
      code_err_q    <= code_err_d;
    end
  end

  assign digits_out  = digits_q;
  assign frame_valid = frame_valid_q;
  assign frame_pulse = frame_pulse_q;
  assign code_err    = code_err_q;

endmodule
